lipsi_bcd_converter: RTL and testbench
======================================

LIPSI_BCD_CONVERTER -- requirements
Module: lipsi_bcd_converter

Interface
REQ-001 SHALL provide parameter IN_W, default 8, binary input width; legal range 4..9, so the result always fits in three BCD digits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream (processor accumulator) offers in_data.
REQ-005 SHALL have port in_ready, output, 1 bit: converter accepts in_data this cycle.
REQ-006 SHALL have port in_data, input, IN_W bits: unsigned binary value to convert.
REQ-007 SHALL have port out_valid, output, 1 bit: digit outputs hold a fresh result.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream display driver consumes the result.
REQ-009 SHALL have ports bcd_hund, bcd_tens and bcd_ones, outputs, 4 bits each: BCD digits of the last completed conversion.
REQ-010 SHALL have port busy, output, 1 bit: high while a conversion is in progress (state SHIFT).

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-012 IDLE: in_ready = 1; on in_valid && in_ready, capture in_data into the binary shift register, clear the BCD scratch register, load the counter with IN_W and go to SHIFT.
REQ-013 SHIFT: each cycle, add 3 to every scratch nibble >= 5, then shift {scratch, binary} left by 1 and decrement the counter; all of this happens in one cycle.
REQ-014 SHIFT: when the counter reaches 0 after the IN_W-th shift, copy the scratch nibbles to bcd_hund, bcd_tens and bcd_ones and go to DONE.
REQ-015 Latency: out_valid SHALL rise exactly IN_W+1 rising edges after the accepting edge.
REQ-016 DONE: out_valid = 1; the digit outputs SHALL remain stable until out_valid && out_ready, after which the FSM returns to IDLE.
REQ-017 in_ready SHALL be 0 in SHIFT and DONE; in_valid is ignored there, and an un-accepted value is not latched.
REQ-018 After the output handshake, the digit outputs SHALL keep their last values; only a new completed conversion updates them.
REQ-019 Back-to-back operation: with out_ready tied high, one conversion SHALL complete every IN_W+2 cycles.
REQ-020 Scratch arithmetic SHALL be 4 bits per nibble; a nibble must never exceed 9 after the final shift, and any value > 9 is a design error.
REQ-021 busy SHALL equal (state == SHIFT); out_valid SHALL equal (state == DONE); both are registered-state derived and glitch-free.

Reset
REQ-022 While reset = 0, the FSM SHALL be in IDLE, with in_ready = 1 (after release), out_valid = 0, busy = 0, all digits 0, and scratch, binary and counter registers 0.
REQ-023 Reset asserted mid-SHIFT or mid-DONE SHALL abort the conversion immediately; no partial digits become visible.
REQ-024 Reset release SHALL take effect synchronously to clk; the first accept is possible on the first rising edge after deassertion.

Structure
REQ-025 Package lipsi_pkg SHALL hold the state enum (IDLE/SHIFT/DONE), the BCD digit width constant (4) and the digit count constant (3).
REQ-026 Sub-module lipsi_bcd_adjust SHALL be one combinational nibble correction (>= 5 -> +3), instantiated three times; everything else is in the top module.
REQ-027 Counter width SHALL be $clog2(IN_W+1) bits.

Verification
REQ-028 Accept in_data = 0 -> after IN_W+1 edges, out_valid = 1 and digits 0/0/0.
REQ-029 Accept 255 -> digits 2/5/5; accept 99 -> 0/9/9; accept 128 -> 1/2/8; each with exact latency 9 edges at IN_W = 8.
REQ-030 Backpressure: hold out_ready = 0 for 10 cycles in DONE with in_valid = 1 and in_data = 7 -> digits stay unchanged, in_ready = 0, and 7 is not captured until after the handshake.
REQ-031 Back-to-back: out_ready = 1, stream 200, 13, 64 -> results 2/0/0, 0/1/3, 0/6/4 at 10-cycle spacing.
REQ-032 Reset pulse during the 4th SHIFT cycle of 255 -> out_valid never rises, digits read 0/0/0, and the next accept of 42 -> 0/4/2.
REQ-033 Exhaustive sweep 0..2^IN_W-1 compared against a divide/modulo reference model; no nibble ever > 9.

Source files
------------

// File: rtl/lipsi_pkg.sv
// Shared types and constants for the LIPSI binary-to-BCD converter.
package lipsi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 3;

endpackage

// File: rtl/lipsi_bcd_adjust.sv
// Double-dabble nibble correction: any digit >= 5 gets +3 before the shift
// so that it carries correctly into the next decade.
module lipsi_bcd_adjust
    import lipsi_pkg::*;
(
    input  logic [DIGIT_W-1:0] nib_i,
    output logic [DIGIT_W-1:0] nib_o
);

    always_comb begin
        nib_o = nib_i;
        if (nib_i >= DIGIT_W'(5)) begin
            nib_o = nib_i + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/lipsi_bcd_converter.sv
// Sequential double-dabble converter: IN_W-bit unsigned binary to three BCD
// digits, one shift per cycle, ready/valid handshakes on both sides.
module lipsi_bcd_converter
    import lipsi_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DIGIT_W-1:0]  bcd_hund,
    output logic [DIGIT_W-1:0]  bcd_tens,
    output logic [DIGIT_W-1:0]  bcd_ones,
    output logic                busy
);

    localparam int CNT_W  = $clog2(IN_W + 1);
    localparam int SCR_W  = DIGIT_W * NUM_DIGITS;

    state_e             state_q, state_d;
    logic [IN_W-1:0]    bin_q,   bin_d;
    logic [SCR_W-1:0]   scr_q,   scr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [SCR_W-1:0]   dig_q,   dig_d;

    logic [SCR_W-1:0]        adj;
    logic [SCR_W+IN_W-1:0]   shift_v;
    logic [SCR_W-1:0]        scr_sh;
    logic [IN_W-1:0]         bin_sh;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        lipsi_bcd_adjust u_adj (
            .nib_i (scr_q[g*DIGIT_W +: DIGIT_W]),
            .nib_o (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Correction and shift happen in the same cycle; the MSB of the corrected
    // scratch falls off, which is safe because IN_W <= 9 never overflows 999.
    assign shift_v = {adj, bin_q} << 1;
    assign scr_sh  = shift_v[SCR_W+IN_W-1:IN_W];
    assign bin_sh  = shift_v[IN_W-1:0];

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = in_data;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(IN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = scr_sh;
                bin_d = bin_sh;
                cnt_d = cnt_q - CNT_W'(1);
                // Last shift: publish the digits straight from the shifter.
                if (cnt_q == CNT_W'(1)) begin
                    dig_d   = scr_sh;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign bcd_hund  = dig_q[2*DIGIT_W +: DIGIT_W];
    assign bcd_tens  = dig_q[1*DIGIT_W +: DIGIT_W];
    assign bcd_ones  = dig_q[0*DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_lipsi_bcd_converter.sv
// Directed bench for lipsi_bcd_converter: latency, backpressure, streaming,
// mid-conversion reset and a full 0..255 sweep against a div/mod model.
module tb_lipsi_bcd_converter;

    localparam int IN_W = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      bcd_hund, bcd_tens, bcd_ones;
    logic            busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          lat, bad, idx, n;
    logic        acc;
    int          vals [3] = '{200, 13, 64};
    int          rc   [3];
    logic [11:0] rd   [3];

    lipsi_bcd_converter #(.IN_W(IN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_hund  (bcd_hund),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input int v);
        logic [3:0] hd, td, od;
        hd = 4'(v / 100);
        td = 4'((v / 10) % 10);
        od = 4'(v % 10);
        return {hd, td, od};
    endfunction

    // Offer v for one edge; lat counts edges with the accepting edge as 1.
    task automatic convert(input int v, output int l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = IN_W'(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_digits",    {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'h000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_in_ready",  {31'd0, in_ready},  32'd1);

        convert(0, lat);
        chk("zero_lat", lat, IN_W + 1);
        chk("zero_dig", {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'h000);
        handshake();
        convert(255, lat);
        chk("d255_lat", lat, 9);
        chk("d255_dig", {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'h255);
        handshake();
        convert(99, lat);
        chk("d99_lat", lat, 9);
        chk("d99_dig", {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'h099);
        handshake();

        // Backpressure: hold DONE with a competing input offered.
        convert(128, lat);
        chk("d128_lat", lat, 9);
        chk("d128_dig", {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'h128);
        in_valid = 1'b1;
        in_data  = 8'd7;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || busy ||
                {bcd_hund, bcd_tens, bcd_ones} != 12'h128) bad++;
        end
        chk("bp_hold", bad, 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_after_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_after_hs_ready", {31'd0, in_ready},  32'd1);
        chk("bp_digits_kept", {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'h128);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_7_lat", lat, 9);
        chk("bp_7_dig", {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'h007);
        handshake();

        // Streaming with out_ready held high.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'(vals[0]);
        idx = 0;
        n   = 0;
        for (int k = 0; k < 60 && n < 3; k++) begin
            acc = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) in_data = 8'(vals[idx]);
                else         in_valid = 1'b0;
            end
            if (out_valid) begin
                rc[n] = cyc;
                rd[n] = {bcd_hund, bcd_tens, bcd_ones};
                n++;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b_count", n, 3);
        chk("b2b_dig0", {20'd0, rd[0]}, 32'h200);
        chk("b2b_dig1", {20'd0, rd[1]}, 32'h013);
        chk("b2b_dig2", {20'd0, rd[2]}, 32'h064);
        chk("b2b_gap01", rc[1] - rc[0], 10);
        chk("b2b_gap12", rc[2] - rc[1], 10);

        // Reset during the 4th SHIFT cycle of 255.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd255;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy},      32'd0);
        chk("mid_rst_dig", {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'h000);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        chk("mid_no_valid", bad, 0);
        chk("mid_dig_zero", {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'h000);
        convert(42, lat);
        chk("d42_lat", lat, 9);
        chk("d42_dig", {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'h042);
        handshake();

        for (int v = 0; v < (1 << IN_W); v++) begin
            convert(v, lat);
            chk($sformatf("sweep_lat_%0d", v), lat, IN_W + 1);
            chk($sformatf("sweep_dig_%0d", v),
                {20'd0, bcd_hund, bcd_tens, bcd_ones}, {20'd0, model(v)});
            chk($sformatf("sweep_le9_%0d", v),
                {31'd0, (bcd_hund <= 4'd9) && (bcd_tens <= 4'd9) && (bcd_ones <= 4'd9)}, 32'd1);
            handshake();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
